clk_monitor: RTL

- Receiving end of the divided slow clock used across the doorlock design.
- Takes an asynchronous slow clock into the system clock domain and synchronises it.
- Emits single-cycle rise/fall ticks for downstream sequential logic.
- Measures the slow-clock period in system clocks and reports lock/loss status, so the doorlock FSMs can run on ticks instead of a derived clock.

---
 rtl/clk_monitor.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/clk_monitor.sv
// clk_monitor: brings the divided slow clock (in_clk) into the system clock
// domain, emits one-cycle rise/fall ticks, measures the rise-to-rise period
// in clk cycles and reports whether that period is stable (locked) or has
// disappeared altogether (lost). Downstream logic runs on the ticks instead
// of on a derived clock.
module clk_monitor #(
    parameter int CNT_W      = 26,
    // Must stay below 2**CNT_W so the saturated count is representable.
    parameter int TIMEOUT    = 1000000,
    parameter int TOL        = 4,
    // Must be at least 1.
    parameter int LOCK_COUNT = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_clk,
    output logic             tick_rise,
    output logic             tick_fall,
    output logic [CNT_W-1:0] period,
    output logic             period_valid,
    output logic             locked,
    output logic             lost
);

    localparam int MATCH_W = (LOCK_COUNT < 1) ? 1 : $clog2(LOCK_COUNT + 1);

    localparam logic [CNT_W-1:0]   TIMEOUT_V = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0]   TOL_V     = CNT_W'(TOL);
    localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1'b1);
    localparam logic [MATCH_W-1:0] LOCK_V    = MATCH_W'(LOCK_COUNT);
    localparam logic [MATCH_W-1:0] MATCH_ONE = MATCH_W'(1'b1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACQ    = 2'd1,
        ST_LOCKED = 2'd2,
        ST_LOST   = 2'd3
    } state_t;

    // Unsigned absolute difference between two counts.
    function automatic logic [CNT_W-1:0] abs_diff(input logic [CNT_W-1:0] a,
                                                  input logic [CNT_W-1:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

    logic               s1_r;
    logic               s2_r;
    logic               s3_r;
    logic [CNT_W-1:0]   cnt_r;
    logic [MATCH_W-1:0] match_r;
    logic               prev_valid_r;
    state_t             state_r;

    logic               rise_s;
    logic               fall_s;
    logic               timeout_s;
    logic               match_ok_s;
    logic [MATCH_W-1:0] match_inc_s;

    // s2/s3 can only disagree in one direction at a time, so rise and fall
    // are mutually exclusive.
    assign rise_s      = s2_r & ~s3_r;
    assign fall_s      = ~s2_r & s3_r;
    assign timeout_s   = (cnt_r == TIMEOUT_V);
    // A period only matches when there is a previous period to compare with.
    assign match_ok_s  = prev_valid_r & (abs_diff(cnt_r, period) <= TOL_V);
    assign match_inc_s = (match_r == LOCK_V) ? match_r : (match_r + MATCH_ONE);

    // Two-flop synchroniser for in_clk plus a history flop for edge detection
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_r <= 1'b0;
            s2_r <= 1'b0;
            s3_r <= 1'b0;
        end else begin
            s1_r <= in_clk;
            s2_r <= s1_r;
            s3_r <= s2_r;
        end
    end

    // Register the edge strobes so the ticks are clean one-cycle pulses
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tick_rise <= 1'b0;
            tick_fall <= 1'b0;
        end else begin
            tick_rise <= rise_s;
            tick_fall <= fall_s;
        end
    end

    // Period counter: restarts at 1 on every rise, saturates at TIMEOUT
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (rise_s) begin
            cnt_r <= CNT_ONE;
        end else if (!timeout_s) begin
            cnt_r <= cnt_r + CNT_ONE;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Lock/loss FSM with period capture and match tracking; a rise always
    // wins over a timeout in the same cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r      <= ST_IDLE;
            match_r      <= {MATCH_W{1'b0}};
            prev_valid_r <= 1'b0;
            period       <= {CNT_W{1'b0}};
            period_valid <= 1'b0;
            locked       <= 1'b0;
            lost         <= 1'b0;
        end else begin
            period_valid <= 1'b0;
            case (state_r)
                // No usable reference yet: the first rise only starts a measurement.
                ST_IDLE, ST_LOST: begin
                    if (rise_s) begin
                        state_r      <= ST_ACQ;
                        prev_valid_r <= 1'b0;
                        match_r      <= {MATCH_W{1'b0}};
                        locked       <= 1'b0;
                        lost         <= 1'b0;
                    end else if (timeout_s) begin
                        state_r <= ST_LOST;
                        locked  <= 1'b0;
                        lost    <= 1'b1;
                    end else begin
                        state_r <= state_r;
                    end
                end
                ST_ACQ: begin
                    if (rise_s) begin
                        period       <= cnt_r;
                        period_valid <= 1'b1;
                        prev_valid_r <= 1'b1;
                        if (match_ok_s) begin
                            match_r <= match_inc_s;
                            if (match_inc_s == LOCK_V) begin
                                state_r <= ST_LOCKED;
                                locked  <= 1'b1;
                            end else begin
                                state_r <= ST_ACQ;
                            end
                        end else begin
                            match_r <= {MATCH_W{1'b0}};
                        end
                    end else if (timeout_s) begin
                        state_r <= ST_LOST;
                        match_r <= {MATCH_W{1'b0}};
                        lost    <= 1'b1;
                    end else begin
                        state_r <= ST_ACQ;
                    end
                end
                // A deviating period drops lock but stays the new reference.
                ST_LOCKED: begin
                    if (rise_s) begin
                        period       <= cnt_r;
                        period_valid <= 1'b1;
                        prev_valid_r <= 1'b1;
                        if (match_ok_s) begin
                            match_r <= match_inc_s;
                        end else begin
                            match_r <= {MATCH_W{1'b0}};
                            state_r <= ST_ACQ;
                            locked  <= 1'b0;
                        end
                    end else if (timeout_s) begin
                        state_r <= ST_LOST;
                        match_r <= {MATCH_W{1'b0}};
                        locked  <= 1'b0;
                        lost    <= 1'b1;
                    end else begin
                        state_r <= ST_LOCKED;
                    end
                end
                default: begin
                    state_r      <= ST_IDLE;
                    match_r      <= {MATCH_W{1'b0}};
                    prev_valid_r <= 1'b0;
                    locked       <= 1'b0;
                    lost         <= 1'b0;
                end
            endcase
        end
    end

endmodule
